// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a ready/valid byte output.
// The RX line passes through a 2-flop synchronizer.
// A framing error gives a one-cycle pulse and the receiver then waits out the line break.
// Overrun is a sticky flag, set when a good frame arrives while the output buffer is full.
// Optional: define UART_RX_PARITY_EN for 8E1 framing. This adds a parity_err pulse output.
module uart_receiver #(
   parameter int unsigned CLOCK_FREQ       = 125_000_000,
   parameter int unsigned BAUD_RATE        = 115_200,
   parameter int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE,  // must be >= 4
   parameter int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2
) (
   input  logic       clk,
   input  logic       rst,             // asynchronous, active low
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       overrun_clr
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int unsigned CntW = $clog2(SYMBOL_EDGE_TIME) + 1;
   localparam logic [CntW-1:0] SampleLast = CntW'(SAMPLE_TIME - 1);
   localparam logic [CntW-1:0] SymbolLast = CntW'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        sync_q;
   logic              rx_s;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;
   logic              buf_free;
`ifdef UART_RX_PARITY_EN
   logic              parity_q, parity_d;
   logic              parity_err_q, parity_err_d;
   logic              parity_ok;
`endif

   assign rx_s     = sync_q[1];
   // The buffer can take a new byte if it is empty or is being drained this cycle.
   assign buf_free = !valid_q || data_out_ready;
`ifdef UART_RX_PARITY_EN
   // Even parity: the data bits and the parity bit together hold an even number of ones.
   assign parity_ok = ~^{shift_q, parity_q};
`endif

   // Synchronizer: resets to the idle-high line level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], serial_in};
      end
   end

   // Next-state logic for the frame FSM, the datapath and the output handshake.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
      parity_d     = parity_q;
      parity_err_d = 1'b0;
`endif

      if (valid_q && data_out_ready) begin
         valid_d = 1'b0;
      end
      // A clear is applied first, so a set event later in this block takes priority.
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == SampleLast) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               // A line that is high again at mid start bit was a glitch.
               state_d   = rx_s ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == SymbolLast) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (cnt_q == SymbolLast) begin
               cnt_d    = '0;
               parity_d = rx_s;
               state_d  = StStop;
            end
         end
`endif
         StStop: begin
            if (cnt_q == SymbolLast) begin
               cnt_d = '0;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end else begin
                  state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                  if (!parity_ok) begin
                     parity_err_d = 1'b1;
                  end else
`endif
                  if (buf_free) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         StBreak: begin
            // Stay here while the line is held low, so a long break yields no more frames.
            cnt_d = '0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity bit and parity error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q     <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         parity_q     <= parity_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign frame_err      = frame_err_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at SYMBOL_EDGE_TIME=10 and SAMPLE_TIME=5.
// The bench changes inputs 1ns after each rising edge.
// The monitor samples DUT outputs on falling edges.
module tb_uart_receiver;

   localparam int unsigned Bit = 10;

   logic       clk;
   logic       rst;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       frame_err;
   logic       overrun;
   logic       overrun_clr;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned rx_count;
   int unsigned fe_count;
   logic [7:0]  sb[$];

   uart_receiver #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .frame_err     (frame_err),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err    (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      serial_in = 1'b0;
      idle(Bit);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         idle(Bit);
      end
      serial_in = stop;
      idle(Bit);
   endtask

   // Monitor: pop and compare on every handshake; count frame_err cycles.
   always @(negedge clk) begin
      if (rst) begin
         if (data_out_valid && data_out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               check("rx_byte", {24'd0, data_out}, {24'd0, sb.pop_front()});
            end
            rx_count++;
         end
         if (frame_err) begin
            fe_count++;
         end
      end
   end

   // Watchdog: ends the run if the sequence stalls.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected sequence completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      int unsigned rx0;
      int unsigned fe0;

      n_tests        = 0;
      n_fail         = 0;
      rx_count       = 0;
      fe_count       = 0;
      rst            = 1'b0;
      serial_in      = 1'b1;
      data_out_ready = 1'b0;
      overrun_clr    = 1'b0;
      idle(3);
      check("rst_data", {24'd0, data_out}, 32'h0);
      check("rst_valid", {31'd0, data_out_valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b1;
      idle(5);

      // 1: 0xA5 with ready high; measure latency from the pin's falling edge.
      data_out_ready = 1'b1;
      sb.push_back(8'hA5);
      lat = -1;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int i = 1; i <= 200; i++) begin
               tick();
               if (data_out_valid) begin
                  lat = i;
                  break;
               end
            end
            tick();
            check("a5_valid_1cyc", {31'd0, data_out_valid}, 32'd0);
         end
      join
      idle(5);
      check("a5_latency", 32'(lat), 32'd98);
      check("a5_rx_count", rx_count, 32'd1);
      check("a5_ferr", fe_count, 32'd0);
      check("a5_overrun", {31'd0, overrun}, 32'd0);

      // 2: 3-cycle glitch, then 0x3C.
      rx0 = rx_count;
      fe0 = fe_count;
      serial_in = 1'b0;
      idle(3);
      serial_in = 1'b1;
      idle(20);
      check("glitch_rx", rx_count, rx0);
      check("glitch_ferr", fe_count, fe0);
      sb.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      idle(5);
      check("3c_rx", rx_count, rx0 + 1);
      check("3c_sb_empty", sb.size(), 32'd0);

      // 3: 0x55 with a low stop bit, line held low, then 0x0F.
      rx0 = rx_count;
      fe0 = fe_count;
      send_frame(8'h55, 1'b0);
      idle(30);
      serial_in = 1'b1;
      idle(15);
      check("brk_ferr_once", fe_count, fe0 + 1);
      check("brk_no_rx", rx_count, rx0);
      sb.push_back(8'h0F);
      send_frame(8'h0F, 1'b1);
      idle(5);
      check("0f_rx", rx_count, rx0 + 1);
      check("0f_ferr", fe_count, fe0 + 1);
      check("0f_sb_empty", sb.size(), 32'd0);

      // 4: overrun with ready low.
      data_out_ready = 1'b0;
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      check("ovr_valid", {31'd0, data_out_valid}, 32'd1);
      check("ovr_data1", {24'd0, data_out}, 32'h11);
      check("ovr_before", {31'd0, overrun}, 32'd0);
      send_frame(8'h22, 1'b1);
      idle(3);
      check("ovr_set", {31'd0, overrun}, 32'd1);
      check("ovr_data_hold", {24'd0, data_out}, 32'h11);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("ovr_clr", {31'd0, overrun}, 32'd0);
      data_out_ready = 1'b1;
      idle(2);
      check("ovr_drained", {31'd0, data_out_valid}, 32'd0);
      check("ovr_sb_empty", sb.size(), 32'd0);

      // 5: back-to-back 0xFF, 0x00 with ready only in the 0x00 stop-sample cycle.
      data_out_ready = 1'b0;
      sb.push_back(8'hFF);
      sb.push_back(8'h00);
      fork
         begin
            send_frame(8'hFF, 1'b1);
            send_frame(8'h00, 1'b1);
         end
         begin
            idle(197);
            check("b2b_ff_held", {24'd0, data_out}, 32'hFF);
            data_out_ready = 1'b1;
            tick();
            data_out_ready = 1'b0;
            check("b2b_valid_kept", {31'd0, data_out_valid}, 32'd1);
            check("b2b_data_00", {24'd0, data_out}, 32'h00);
         end
      join
      check("b2b_overrun", {31'd0, overrun}, 32'd0);
      data_out_ready = 1'b1;
      idle(2);
      check("b2b_sb_empty", sb.size(), 32'd0);

      // 6: asynchronous reset during bit 4, then 0x81.
      data_out_ready = 1'b0;
      send_frame(8'h77, 1'b1);
      send_frame(8'h66, 1'b1);
      idle(2);
      check("pre_rst_valid", {31'd0, data_out_valid}, 32'd1);
      check("pre_rst_overrun", {31'd0, overrun}, 32'd1);
      rx0 = rx_count;
      fork
         send_frame(8'hC3, 1'b1);
         begin
            idle(55);
            rst = 1'b0;
            #1;
            check("mid_rst_data", {24'd0, data_out}, 32'h0);
            check("mid_rst_valid", {31'd0, data_out_valid}, 32'd0);
            check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
            check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
         end
      join
      rst = 1'b1;
      data_out_ready = 1'b1;
      idle(5);
      check("post_rst_valid", {31'd0, data_out_valid}, 32'd0);
      sb.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      idle(5);
      check("81_rx", rx_count, rx0 + 1);
      check("81_sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver for the `serial_in` pin of the memory-mapped IO controller.
- Frame format is 8N1: start bit, 8 data bits LSB first, 1 stop bit.
- Received bytes are presented on a ready/valid interface; the IO controller's read logic consumes them.
- Reports framing errors and overrun to the CPU.

Parameters:
- CLOCK_FREQ, 125_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits per second.
- SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE, clock cycles per bit. Must be >= 4.
- SAMPLE_TIME, SYMBOL_EDGE_TIME/2, cycles from the start-bit edge to the start-bit sample.

Ports:
- clk  input  1  core clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- serial_in  input  1  asynchronous RX line; idles high.
- data_out  output  8  received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts the byte when valid & ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a completed frame was dropped because the output buffer was full.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; all counters 0.
  - Synchronizer flops = 1.
  - data_out = 0, data_out_valid = 0, frame_err = 0, overrun = 0.
- Input synchronization: 2-flop synchronizer on serial_in. rx_s is the synchronized value, 2 cycles of latency. All behaviour below refers to rx_s.
- Bit counter: width $clog2(SYMBOL_EDGE_TIME)+1. Bit index: 0..7. Shift register: 8 bits, fills LSB first.
- Let t0 be the first cycle rx_s = 0 while in IDLE.
- IDLE: rx_s = 0 -> START, counter cleared.
- START: at t0+SAMPLE_TIME, sample rx_s.
  - 0 -> DATA.
  - 1 -> glitch; return to IDLE with no outputs.
- DATA: bit i (i = 0..7) is sampled at t0+SAMPLE_TIME+(i+1)*SYMBOL_EDGE_TIME. After bit 7 -> STOP.
- STOP: sample at t0+SAMPLE_TIME+9*SYMBOL_EDGE_TIME.
  - Stop = 1, buffer free:
    - Buffer free means data_out_valid = 0, or data_out_ready = 1 in this same cycle.
    - data_out <= shift register; data_out_valid = 1 from the next cycle.
    - -> IDLE.
  - Stop = 1, buffer full: byte discarded; data_out unchanged; overrun <= 1. -> IDLE.
  - Stop = 0: frame_err pulses high for exactly one cycle (next cycle); byte discarded. -> BREAK.
- BREAK: wait until rx_s = 1, then -> IDLE. A held-low line produces no further frames or errors.
- Output handshake:
  - data_out_valid falls the cycle after valid & ready, unless a new byte loads in the same cycle (then valid stays 1).
  - data_out is stable while valid = 1 and not accepted.
- overrun:
  - Cleared by overrun_clr = 1.
  - If a set event and overrun_clr occur in the same cycle, set wins.
- A new start edge is detected in IDLE on the cycle after STOP completes; back-to-back frames need no idle gap beyond the stop bit.
- Reset asserted mid-frame: immediate return to the reset state; the partial byte is lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit is sampled one SYMBOL_EDGE_TIME after bit 7, via a PARITY state before STOP.
  - Output port parity_err (1 bit) pulses for one cycle the cycle after the stop sample when parity mismatches; the byte is discarded.
  - Framing error takes priority over parity error; only frame_err pulses.
  - The stop sample moves to t0+SAMPLE_TIME+10*SYMBOL_EDGE_TIME.
- Undefined: 8N1 as above; no parity_err port.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100 -> SYMBOL_EDGE_TIME=10, SAMPLE_TIME=5):
- Send 0xA5 with data_out_ready=1 -> data_out_valid high for 1 cycle, data_out=0xA5, rising 2+5+90+1 cycles after the pin's falling edge; frame_err=0, overrun=0.
- Pulse serial_in low for 3 cycles -> no valid, no frame_err; a following frame 0x3C is received correctly.
- Send 0x55 with stop bit 0, hold line low 30 cycles, then send 0x0F -> one frame_err pulse only, no valid for 0x55; 0x0F delivered.
- data_out_ready=0; send 0x11 then 0x22 -> data_out=0x11 remains valid, overrun=1 after the second stop sample; overrun_clr=1 -> overrun=0; ready=1 -> 0x11 consumed.
- Back-to-back 0xFF,0x00 with ready asserted in the cycle the 0x00 stop is sampled -> valid stays 1, data_out 0xFF then 0x00, no overrun.
- Assert rst=0 during bit 4 of a frame -> all outputs 0 immediately; after release, frame 0x81 received correctly.
